bcp_scheduler: RTL and testbench

Sequencer for Boolean constraint propagation: walks the clause memory one clause at a time and feeds each clause to an internal `unit_clause_eval` instance. Every unit clause it finds becomes an implication, sent out on a ready/valid stream; it stops early if a clause evaluates to a conflict. It sits between the clause RAM, the variable assignment table and the decision/trail controller that consumes implications.

---
 rtl/bcp_scheduler_pkg.sv | 30 +++
 rtl/bcp_scheduler_if.sv | 28 ++
 rtl/bcp_scheduler_eval.sv | 32 +++
 rtl/bcp_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_bcp_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcp_scheduler_pkg.sv
// Shared types and sizing for the BCP clause scheduler slice.
package sat_pkg;

  localparam int unsigned VAR_PER_CLAUSE = 5;
  localparam int unsigned NUM_VARIABLE   = 128;
  localparam int unsigned VARIABLE_INDEX = 6;
  localparam int unsigned NUM_CLAUSE     = 256;
  localparam int unsigned CLAUSE_INDEX   = 7;

  localparam int unsigned VAR_W  = VARIABLE_INDEX + 1;
  localparam int unsigned ADDR_W = CLAUSE_INDEX + 1;
  localparam int unsigned CNT_W  = CLAUSE_INDEX + 2;
  localparam int unsigned SLOT_W = $clog2(VAR_PER_CLAUSE);

  typedef struct packed {
    logic [VAR_PER_CLAUSE-1:0]            mask;
    logic [VAR_PER_CLAUSE-1:0]            pole;
    logic [VAR_PER_CLAUSE-1:0][VAR_W-1:0] variable;
  } clause_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EVAL,
    EMIT,
    FINISH
  } bcp_state_t;

endpackage

// File: rtl/bcp_scheduler_if.sv
// Clause RAM read port and implication stream between scheduler and its neighbours.
interface bcp_scheduler_if;
  import sat_pkg::*;

  logic              clause_rd_en;
  logic [ADDR_W-1:0] clause_rd_addr;
  clause_t           clause_rd_data;

  logic              impl_valid;
  logic              impl_ready;
  logic [VAR_W-1:0]  impl_var;
  logic              impl_val;

  modport master (
    output clause_rd_en, clause_rd_addr,
    input  clause_rd_data,
    output impl_valid, impl_var, impl_val,
    input  impl_ready
  );

  modport slave (
    input  clause_rd_en, clause_rd_addr,
    output clause_rd_data,
    input  impl_valid, impl_var, impl_val,
    output impl_ready
  );

endinterface

// File: rtl/bcp_scheduler_eval.sv
// Combinational classification of one clause: conflict, or unit with its implied literal.
module unit_clause_eval
  import sat_pkg::*;
(
  input  logic [VAR_PER_CLAUSE-1:0] mask,
  input  logic [VAR_PER_CLAUSE-1:0] pole,
  input  logic [VAR_PER_CLAUSE-1:0] unassign,
  input  logic [VAR_PER_CLAUSE-1:0] val,
  output logic                      conflict_c,
  output logic                      unit_clause_c,
  output logic [VAR_PER_CLAUSE-1:0] implied_variable_c,
  output logic                      new_val_c
);

  logic [VAR_PER_CLAUSE-1:0] lit_sat;
  logic [VAR_PER_CLAUSE-1:0] open_lit;
  logic                      satisfied;
  logic                      single_open;

  assign lit_sat     = mask & ~unassign & (val ^ pole);
  assign open_lit    = mask & unassign;
  assign satisfied   = |lit_sat;
  // Power-of-two test: exactly one open literal remains.
  assign single_open = (open_lit != '0) &&
                       ((open_lit & (open_lit - VAR_PER_CLAUSE'(1))) == '0);

  assign conflict_c         = (|mask) && !satisfied && (open_lit == '0);
  assign unit_clause_c      = !satisfied && single_open;
  assign implied_variable_c = unit_clause_c ? open_lit : '0;
  assign new_val_c          = ~|(pole & implied_variable_c);

endmodule

// File: rtl/bcp_scheduler.sv
// Walks clause memory, evaluates each clause and streams out unit implications.
module bcp_scheduler
  import sat_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        num_clauses,
  input  logic [NUM_VARIABLE-1:0] var_unassign,
  input  logic [NUM_VARIABLE-1:0] var_val,
  bcp_scheduler_if.master         bus,
  output logic                    busy,
  output logic                    done,
  output logic                    conflict,
  output logic [ADDR_W-1:0]       conflict_clause,
  output logic [CNT_W-1:0]        impl_count
);

  bcp_state_t                state;
  logic [CNT_W-1:0]          idx;
  logic [CNT_W-1:0]          n_clauses;
  logic [CNT_W-1:0]          idx_next;
  logic                      last;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      impl_valid;
  logic [VAR_W-1:0]          impl_var;
  logic                      impl_val;
  clause_t                   clause_q;
  logic [VAR_PER_CLAUSE-1:0] unassign_q;
  logic [VAR_PER_CLAUSE-1:0] val_q;

  logic                      eval_conflict_c;
  logic                      eval_unit_c;
  logic [VAR_PER_CLAUSE-1:0] eval_implied_c;
  logic                      eval_new_val_c;

  function automatic logic [SLOT_W-1:0] onehot2idx(input logic [VAR_PER_CLAUSE-1:0] oh);
    logic [SLOT_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (oh[i]) pos = pos | SLOT_W'(i);
    end
    return pos;
  endfunction

  assign idx_next = idx + CNT_W'(1);
  assign last     = (idx_next == n_clauses);

  assign bus.clause_rd_en   = rd_en;
  assign bus.clause_rd_addr = rd_addr;
  assign bus.impl_valid     = impl_valid;
  assign bus.impl_var       = impl_var;
  assign bus.impl_val       = impl_val;

  unit_clause_eval u_eval (
    .mask               (clause_q.mask),
    .pole               (clause_q.pole),
    .unassign           (unassign_q),
    .val                (val_q),
    .conflict_c         (eval_conflict_c),
    .unit_clause_c      (eval_unit_c),
    .implied_variable_c (eval_implied_c),
    .new_val_c          (eval_new_val_c)
  );

  // Pass sequencer; strobes (rd_en, done) are set on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      n_clauses       <= '0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      clause_q        <= '0;
      unassign_q      <= '0;
      val_q           <= '0;
      impl_valid      <= 1'b0;
      impl_var        <= '0;
      impl_val        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      impl_count      <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy            <= 1'b1;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            impl_count      <= '0;
            idx             <= '0;
            n_clauses       <= num_clauses;
            rd_addr         <= '0;
            if (num_clauses == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              rd_en <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            clause_q <= bus.clause_rd_data;
            for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
              unassign_q[i] <= var_unassign[bus.clause_rd_data.variable[i]];
              val_q[i]      <= var_val[bus.clause_rd_data.variable[i]];
            end
            state <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (eval_conflict_c) begin
            conflict        <= 1'b1;
            conflict_clause <= idx[ADDR_W-1:0];
            state           <= FINISH;
            done            <= 1'b1;
          end else if (eval_unit_c) begin
            impl_valid <= 1'b1;
            impl_var   <= clause_q.variable[onehot2idx(eval_implied_c)];
            impl_val   <= eval_new_val_c;
            state      <= EMIT;
          end else begin
            idx <= idx_next;
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              rd_en   <= 1'b1;
              rd_addr <= idx_next[ADDR_W-1:0];
            end
          end
        end
        EMIT: begin
          if (abort) begin
            impl_valid <= 1'b0;
            state      <= FINISH;
            done       <= 1'b1;
          end else if (bus.impl_ready) begin
            impl_valid <= 1'b0;
            impl_count <= impl_count + CNT_W'(1);
            idx        <= idx_next;
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              rd_en   <= 1'b1;
              rd_addr <= idx_next[ADDR_W-1:0];
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_scheduler.sv
// Scoreboard bench for bcp_scheduler: a reference model queues expected implications per pass.
module tb_bcp_scheduler;
  import sat_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    abort;
  logic [CNT_W-1:0]        num_clauses;
  logic [NUM_VARIABLE-1:0] var_unassign;
  logic [NUM_VARIABLE-1:0] var_val;
  logic                    busy;
  logic                    done;
  logic                    conflict;
  logic [ADDR_W-1:0]       conflict_clause;
  logic [CNT_W-1:0]        impl_count;

  bcp_scheduler_if bus();

  bcp_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .num_clauses     (num_clauses),
    .var_unassign    (var_unassign),
    .var_val         (var_val),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .conflict        (conflict),
    .conflict_clause (conflict_clause),
    .impl_count      (impl_count)
  );

  always #5 clk = ~clk;

  clause_t    mem [NUM_CLAUSE];
  logic [7:0] exp_q [$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         stall_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous clause RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.clause_rd_en) bus.clause_rd_data <= mem[bus.clause_rd_addr];
  end

  // Consumer: holds ready low for stall_len cycles of every offered implication.
  initial begin : ready_drv
    int wait_cnt;
    wait_cnt = 0;
    bus.impl_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bus.impl_valid) begin
        wait_cnt = 0;
        bus.impl_ready = (stall_len == 0);
      end else if (wait_cnt < stall_len) begin
        wait_cnt++;
        bus.impl_ready = 1'b0;
      end else begin
        bus.impl_ready = 1'b1;
      end
    end
  end

  logic [7:0] pl;
  logic [7:0] prev_pl;
  bit         prev_hold;
  int         stall_seen;

  // Implication monitor: payload stability while stalled, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold  = 1'b0;
      stall_seen = 0;
    end else if (bus.impl_valid) begin
      pl = {bus.impl_var, bus.impl_val};
      if (prev_hold) check("impl_stable", pl, prev_pl);
      if (bus.impl_ready && !abort) begin
        check("impl_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("impl_payload", pl, exp_q.pop_front());
        check("impl_stall", stall_seen, stall_len);
        stall_seen = 0;
        prev_hold  = 1'b0;
      end else begin
        stall_seen++;
        prev_hold = 1'b1;
        prev_pl   = pl;
      end
    end else begin
      prev_hold  = 1'b0;
      stall_seen = 0;
    end
  end

  function automatic clause_t mk(input logic [4:0] m, input logic [4:0] p,
                                 input int a, input int b, input int c);
    clause_t cl;
    cl = '0;
    cl.mask = m;
    cl.pole = p;
    cl.variable[0] = 7'(a);
    cl.variable[1] = 7'(b);
    cl.variable[2] = 7'(c);
    return cl;
  endfunction

  // Reference model of one pass: fills exp_q and predicts timing and outcome.
  task automatic model(input int n, output int cyc, output int reads, output bit cf,
                       output int cf_idx, output int nimp);
    cyc = 0; reads = 0; cf = 1'b0; cf_idx = 0; nimp = 0;
    for (int c = 0; c < n; c++) begin
      clause_t cl;
      int open_n, sat_n, slot;
      cl = mem[c]; open_n = 0; sat_n = 0; slot = 0;
      reads++;
      cyc += 3;
      for (int s = 0; s < VAR_PER_CLAUSE; s++) begin
        if (cl.mask[s]) begin
          if (var_unassign[cl.variable[s]]) begin
            open_n++;
            slot = s;
          end else if (var_val[cl.variable[s]] != cl.pole[s]) begin
            sat_n++;
          end
        end
      end
      if (cl.mask != '0 && sat_n == 0) begin
        if (open_n == 0) begin
          cf = 1'b1;
          cf_idx = c;
          break;
        end
        if (open_n == 1) begin
          exp_q.push_back({cl.variable[slot], ~cl.pole[slot]});
          nimp++;
          cyc += 1 + stall_len;
        end
      end
    end
    cyc += 1;
  endtask

  task automatic start_pass(input int n);
    @(posedge clk); #1;
    num_clauses = CNT_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int reads);
    bit got;
    cyc = 0; reads = 0; got = 1'b0;
    while (!got && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (bus.clause_rd_en) reads++;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", got, 1);
  endtask

  task automatic run_pass(input int n, input string tag);
    int exp_cyc, exp_reads, exp_cf_idx, exp_imp, cyc, reads;
    bit exp_cf;
    model(n, exp_cyc, exp_reads, exp_cf, exp_cf_idx, exp_imp);
    start_pass(n);
    wait_done(cyc, reads);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_reads"}, reads, exp_reads);
    check({tag, "_busy_fin"}, busy, 1);
    check({tag, "_conflict"}, conflict, exp_cf);
    if (exp_cf) check({tag, "_cf_clause"}, conflict_clause, exp_cf_idx);
    check({tag, "_impl_count"}, impl_count, exp_imp);
    check({tag, "_q_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    exp_q.delete();
  endtask

  initial begin : main
    int cyc, reads, cf_idx, nimp;
    bit cf, got, done_seen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_clauses = '0;
    var_unassign = '1; var_val = '0; stall_len = 0;
    for (int i = 0; i < NUM_CLAUSE; i++) mem[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus.clause_rd_en, 0);
    check("rst_impl_valid", bus.impl_valid, 0);
    check("rst_conflict", conflict, 0);
    check("rst_impl_count", impl_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_pass(0, "empty");

    // x3=0, x7=0 assigned, x9 open: positive clause implies x9=1.
    var_unassign[3] = 1'b0; var_unassign[7] = 1'b0;
    mem[0] = mk(5'b00111, 5'b00000, 3, 7, 9);
    run_pass(1, "unit");
    stall_len = 6;
    run_pass(1, "stall");
    stall_len = 0;

    mem[0] = mk(5'b00001, 5'b00001, 3, 0, 0);
    mem[1] = mk(5'b00011, 5'b00000, 3, 7, 0);
    mem[2] = mk(5'b00001, 5'b00000, 9, 0, 0);
    run_pass(3, "conflict");

    // Asynchronous reset while in LOAD.
    start_pass(3);
    @(negedge clk);
    check("rst_mid_fetch", bus.clause_rd_en, 1);
    @(posedge clk); #1 rst = 1'b1; #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_conflict", conflict, 0);
    check("rst_mid_cf_clause", conflict_clause, 0);
    check("rst_mid_rd_en", bus.clause_rd_en, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;
    done_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    check("rst_mid_no_done", done_seen, 0);

    mem[0] = mk(5'b00011, 5'b00001, 3, 9, 0);
    mem[1] = mk(5'b00000, 5'b00000, 9, 0, 0);
    run_pass(2, "skip");

    // Abort while the implication of clause 5 of 10 is stalled.
    for (int i = 0; i < 10; i++) mem[i] = '0;
    mem[1] = mk(5'b00001, 5'b00000, 9, 0, 0);
    mem[5] = mk(5'b00011, 5'b00001, 20, 3, 0);
    stall_len = 3;
    model(10, cyc, reads, cf, cf_idx, nimp);
    start_pass(10);
    got = 1'b0; done_seen = 1'b0; cyc = 0;
    while (!got && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus.clause_rd_en && bus.clause_rd_addr == 8'd5) done_seen = 1'b1;
      if (done_seen && bus.impl_valid) got = 1'b1;
    end
    check("abort_reach", got, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_done", done, 1);
    check("abort_valid", bus.impl_valid, 0);
    check("abort_impl_count", impl_count, 1);
    check("abort_dropped", exp_q.size(), 1);
    @(negedge clk);
    check("abort_idle", busy, 0);
    exp_q.delete();

    // Full-depth pass: slot 0 always open, so no conflicts and no index wrap.
    stall_len = 0;
    for (int v = 0; v < NUM_VARIABLE; v++) begin
      var_unassign[v] = (v < 64);
      var_val[v] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < NUM_CLAUSE; c++) begin
      mem[c].mask = 5'($urandom) | 5'b00001;
      mem[c].pole = 5'($urandom);
      mem[c].variable[0] = 7'($urandom_range(0, 63));
      for (int s = 1; s < VAR_PER_CLAUSE; s++) mem[c].variable[s] = 7'($urandom_range(0, 127));
    end
    run_pass(NUM_CLAUSE, "full");

    // Mostly-assigned table: conflicts likely somewhere in the scan.
    stall_len = 2;
    for (int v = 0; v < NUM_VARIABLE; v++) var_unassign[v] = ($urandom_range(0, 7) == 0);
    for (int c = 0; c < 40; c++) begin
      mem[c].mask = 5'($urandom);
      mem[c].pole = 5'($urandom);
      for (int s = 0; s < VAR_PER_CLAUSE; s++) mem[c].variable[s] = 7'($urandom_range(0, 127));
    end
    run_pass(40, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
